fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arb_pkg.sv | 18 +
 rtl/fifo_wr_arbiter_rr_arbiter.sv | 43 ++++
 rtl/fifo_wr_arbiter.sv | 88 ++++++++
 tb/tb_fifo_wr_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// Shared helpers for the FIFO write-side arbiter: pointer/grant widths and Gray encoding.
package fifo_wr_arb_pkg;

    localparam int GRAY_W = 32;

    function automatic int ptr_w(input int addr_size);
        return addr_size + 1;
    endfunction

    function automatic int gid_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: search begins at last+1, or at last itself
// when advance is low so the current owner can keep its grant.
module rr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GW      = gid_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      last,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt,
    output logic [GW-1:0]      gnt_idx
);

    logic [GW:0]   start;
    logic [GW:0]   sum;
    logic [GW-1:0] idx;
    logic          found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        start   = {1'b0, last} + {{GW{1'b0}}, advance};
        if (start >= (GW+1)'(NUM_REQ))
            start = start - (GW+1)'(NUM_REQ);
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = start + (GW+1)'(k);
            if (sum >= (GW+1)'(NUM_REQ))
                sum = sum - (GW+1)'(NUM_REQ);
            idx = sum[GW-1:0];
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side scheduler: round-robin shares the memory write port, owns the write
// pointer and registered full flag. Define FIFO_WR_ARB_BURST_EN for burst grants.
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 6,
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                           wclk,
    input  logic                           wrst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [ADDR_SIZE:0]             wq2_rptr,
    output logic [DATA_SIZE-1:0]           wdata,
    output logic [ADDR_SIZE-1:0]           waddr,
    output logic                           wclken,
    output logic                           wfull,
    output logic [ADDR_SIZE:0]             wptr,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id
);

    localparam int PW = ptr_w(ADDR_SIZE);
    localparam int GW = gid_w(NUM_REQ);
    localparam int A  = ADDR_SIZE;

    logic [PW-1:0]      wbin, wbinnext, wgraynext;
    logic [GW-1:0]      last, gnt_idx;
    logic [NUM_REQ-1:0] cand, gnt;
    logic               advance, fire, full_next;

    assign cand = wfull ? '0 : req_valid;

`ifdef FIFO_WR_ARB_BURST_EN
    localparam int BW = $clog2(BURST_LEN + 1);
    logic [BW-1:0] beat;

    // Stay on the owner until it has used its burst; then search from last+1.
    assign advance = (beat >= BW'(BURST_LEN));

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst)
            beat <= '0;
        else if (fire)
            beat <= (gnt_idx == last && !advance) ? beat + BW'(1) : BW'(1);
    end
`else
    assign advance = 1'b1;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ), .GW(GW)) u_rr (
        .req     (cand),
        .last    (last),
        .advance (advance),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Reset cancels the handshake combinationally so nothing is written.
    assign req_ready = wrst ? '0 : gnt;
    assign fire      = |(req_ready & req_valid);
    assign wclken    = fire;
    assign wdata     = req_data[gnt_idx*DATA_SIZE +: DATA_SIZE];
    assign waddr     = wbin[A-1:0];
    assign grant_id  = gnt_idx;

    assign wbinnext  = wbin + PW'(fire);
    assign wgraynext = PW'(bin2gray(GRAY_W'(wbinnext)));
    assign full_next = (wgraynext == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]});

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin  <= '0;
            wptr  <= '0;
            wfull <= 1'b0;
            last  <= GW'(NUM_REQ - 1);
        end else begin
            wbin  <= wbinnext;
            wptr  <= wgraynext;
            wfull <= full_next;
            if (fire)
                last <= gnt_idx;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter (NUM_REQ=4, ADDR_SIZE=2, BURST_LEN=2).
module tb_fifo_wr_arbiter;

    localparam int DS = 32;
    localparam int AS = 2;
    localparam int NR = 4;

    logic              wclk = 1'b0;
    logic              wrst;
    logic [NR-1:0]     req_valid;
    logic [NR*DS-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic [AS:0]       wq2_rptr;
    logic [DS-1:0]     wdata;
    logic [AS-1:0]     waddr;
    logic              wclken;
    logic              wfull;
    logic [AS:0]       wptr;
    logic [1:0]        grant_id;

    fifo_wr_arbiter #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .NUM_REQ(NR), .BURST_LEN(2)) dut (
        .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .wq2_rptr(wq2_rptr), .wdata(wdata), .waddr(waddr),
        .wclken(wclken), .wfull(wfull), .wptr(wptr), .grant_id(grant_id)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic [1:0]    gid;
        logic [AS-1:0] addr;
        logic [DS-1:0] data;
    } exp_t;

    exp_t       sbq[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] tag = 8'h00;
    logic [AS:0] gtab [0:10] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111,
                                 3'b101, 3'b100, 3'b000, 3'b001, 3'b011};

    // Distinct data per requester and per test so a wrong slice is visible.
    always_comb
        for (int i = 0; i < NR; i++)
            req_data[i*DS +: DS] = {tag, 8'h5A, 16'(i)};

    function automatic exp_t mk(input int gid, input int addr);
        exp_t e;
        e.gid  = 2'(gid);
        e.addr = AS'(addr);
        e.data = {tag, 8'h5A, 16'(gid)};
        return e;
    endfunction

    // Monitor: every write the DUT performs must match the head of the scoreboard.
    always @(negedge wclk) begin
        if (!wrst && wclken) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: grant_id=%0d waddr=%0d, none expected", grant_id, waddr);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (grant_id !== e.gid || waddr !== e.addr || wdata !== e.data ||
                    req_ready !== (NR'(1) << grant_id)) begin
                    errors++;
                    $display("FAIL write: got gid=%0d addr=%0d data=%h rdy=%b, want gid=%0d addr=%0d data=%h",
                             grant_id, waddr, wdata, req_ready, e.gid, e.addr, e.data);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge wclk); #1;
        wrst = 1'b1; req_valid = '0; wq2_rptr = '0;
        @(posedge wclk); #1;
        wrst = 1'b0;
    endtask

    task automatic test_reset();
        wrst = 1'b1; req_valid = 4'hF; wq2_rptr = '0; tag = 8'h01;
        @(posedge wclk); #1;
        checks++;
        if (req_ready !== 4'b0 || wclken !== 1'b0 || wptr !== 3'b000 || wfull !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b wclken=%b wptr=%b wfull=%b, want 0", req_ready, wclken, wptr, wfull);
        end
        req_valid = '0;
        wrst = 1'b0;
    endtask

    task automatic test_fill();
        int n;
        tag = 8'h02;
        for (int i = 0; i < 4; i++) sbq.push_back(mk(i, i));
        req_valid = 4'hF;
        n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(posedge wclk); #2; n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL fill_timeout: %0d writes outstanding, want 0", sbq.size());
        end
        checks++;
        if (wfull !== 1'b1 || wptr !== 3'b110 || req_ready !== 4'b0) begin
            errors++;
            $display("FAIL fill_full: wfull=%b wptr=%b rdy=%b, want 1 110 0000", wfull, wptr, req_ready);
        end
        @(posedge wclk); #2;
        checks++;
        if (req_ready !== 4'b0 || wclken !== 1'b0) begin
            errors++;
            $display("FAIL full_holdoff: rdy=%b wclken=%b, want 0000 0", req_ready, wclken);
        end
    endtask

    task automatic test_drain();
        // Reader frees one slot; exactly one write (requester 0, addr 0) refills it.
        wq2_rptr = 3'b001;
        sbq.push_back(mk(0, 0));
        @(posedge wclk); #2;
        checks++;
        if (wfull !== 1'b0) begin
            errors++;
            $display("FAIL drain_deassert: wfull=%b, want 0", wfull);
        end
        @(posedge wclk); #2;
        checks++;
        if (wfull !== 1'b1 || wptr !== 3'b111 || sbq.size() != 0) begin
            errors++;
            $display("FAIL drain_refill: wfull=%b wptr=%b pending=%0d, want 1 111 0", wfull, wptr, sbq.size());
        end
        req_valid = '0;
    endtask

    task automatic test_single_wrap();
        do_reset();
        tag = 8'h03;
        for (int k = 0; k < 10; k++) sbq.push_back(mk(2, k % 4));
        req_valid = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            @(posedge wclk); #1;
            checks++;
            if (wptr !== gtab[k+1] || wfull !== 1'b0) begin
                errors++;
                $display("FAIL single_wptr[%0d]: wptr=%b wfull=%b, want %b 0", k, wptr, wfull, gtab[k+1]);
            end
            wq2_rptr = wptr;
        end
        req_valid = '0;
        @(posedge wclk); #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL single_count: %0d writes outstanding, want 0", sbq.size());
        end
    endtask

    task automatic test_reset_mid();
        tag = 8'h04;
        @(posedge wclk); #1;
        req_valid = 4'hF;
        #2 wrst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0 || wclken !== 1'b0 || wptr !== 3'b000 || wfull !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: rdy=%b wclken=%b wptr=%b wfull=%b, want 0", req_ready, wclken, wptr, wfull);
        end
        wq2_rptr = '0;
        @(posedge wclk); #1;
        sbq.push_back(mk(0, 0));
        sbq.push_back(mk(1, 1));
        wrst = 1'b0;
        @(posedge wclk); #1;
        @(posedge wclk); #1;
        req_valid = '0;
        checks++;
        if (sbq.size() != 0 || wptr !== 3'b011) begin
            errors++;
            $display("FAIL reset_mid_resume: pending=%0d wptr=%b, want 0 011", sbq.size(), wptr);
        end
    endtask

    task automatic test_two_req();
        int seq [0:5];
`ifdef FIFO_WR_ARB_BURST_EN
        seq = '{0, 0, 1, 1, 0, 0};
`else
        seq = '{0, 1, 0, 1, 0, 1};
`endif
        do_reset();
        tag = 8'h05;
        for (int k = 0; k < 6; k++) sbq.push_back(mk(seq[k], k % 4));
        req_valid = 4'b0011;
        for (int k = 0; k < 6; k++) begin
            @(posedge wclk); #1;
            wq2_rptr = wptr;
        end
        req_valid = '0;
        @(posedge wclk); #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL two_req_count: %0d writes outstanding, want 0", sbq.size());
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_single_wrap();
        test_reset_mid();
        test_two_req();
        repeat (2) @(posedge wclk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d writes never seen, want 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
